// File: rtl/sram_client_pkg.sv
// Shared definitions for SRAM controller port clients: bus widths,
// client sequencing states and wrapping address arithmetic.
package sram_client_pkg;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 16;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
    typedef logic [SRAM_DATA_W-1:0] sram_data_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_ACK,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_GAP,
        S_DONE
    } client_state_e;

    // Base plus word index; wraps modulo 2^SRAM_ADDR_W.
    function automatic sram_addr_t addr_at(input sram_addr_t base, input logic [15:0] idx);
        return base + sram_addr_t'(idx);
    endfunction

endpackage

// File: rtl/sram_sync2.sv
// Two-flop level synchronizer for a single control bit, reset to 0.
module sram_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sram_copy_client.sv
// Block-copy engine on one SRAM controller client port. Reads src+i,
// waits for the DataReady low/high handshake, then writes the word to dst+i.
// Optional fill mode (write cmd_pattern, no reads) enabled by the macro
// SRAM_COPY_FILL_EN; without it every command is a copy.
module sram_copy_client
    import sram_client_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned WR_GAP      = 2
) (
    input  logic                   BOARD_CLK,
    input  logic                   RESET_N,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [SRAM_ADDR_W-1:0] cmd_src,
    input  logic [SRAM_ADDR_W-1:0] cmd_dst,
    input  logic [15:0]            cmd_len,
    input  logic                   cmd_fill,
    input  logic [SRAM_DATA_W-1:0] cmd_pattern,
    output logic [SRAM_ADDR_W-1:0] AddressToSRAM,
    output logic [SRAM_DATA_W-1:0] DataToSRAM,
    output logic                   QueueReadReq,
    output logic                   QueueWriteReq,
    input  logic                   DataReady,
    input  logic [SRAM_DATA_W-1:0] DataFromSRAM,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [15:0]            words_done
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT) + 1;
    localparam int unsigned GAP_W = $clog2(WR_GAP + 1) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (WR_GAP == 0) ? '0 : GAP_W'(WR_GAP - 1);

    client_state_e state_q, state_d;
    sram_addr_t    src_q, src_d;
    sram_addr_t    dst_q, dst_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   idx_q, idx_d;
    sram_data_t    data_q, data_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic          error_q, error_d;
    logic [15:0]   words_done_q, words_done_d;

    logic          ready_sync;
    logic          last_word;
    logic          fill_mode;
    logic          start_fill;
    sram_data_t    wr_data;
    client_state_e next_after_gap;

`ifdef SRAM_COPY_FILL_EN
    logic          fill_q, fill_d;
    sram_data_t    pattern_q, pattern_d;

    assign fill_mode  = fill_q;
    assign start_fill = cmd_fill;
    assign wr_data    = fill_q ? pattern_q : data_q;
`else
    logic          unused_fill_inputs;

    assign unused_fill_inputs = ^{cmd_fill, cmd_pattern};
    assign fill_mode  = 1'b0;
    assign start_fill = 1'b0;
    assign wr_data    = data_q;
`endif

    sram_sync2 u_ready_sync (
        .clk   (BOARD_CLK),
        .rst_n (RESET_N),
        .d     (DataReady),
        .q     (ready_sync)
    );

    // State and datapath registers.
    always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            error_q      <= 1'b0;
            words_done_q <= '0;
`ifdef SRAM_COPY_FILL_EN
            fill_q       <= 1'b0;
            pattern_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            error_q      <= error_d;
            words_done_q <= words_done_d;
`ifdef SRAM_COPY_FILL_EN
            fill_q       <= fill_d;
            pattern_q    <= pattern_d;
`endif
        end
    end

    // Next-state and datapath update: command latch, handshake waits with timeout, write pacing.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        idx_d        = idx_q;
        data_d       = data_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        error_d      = error_q;
        words_done_d = words_done_q;
`ifdef SRAM_COPY_FILL_EN
        fill_d       = fill_q;
        pattern_d    = pattern_q;
`endif
        last_word      = (idx_q + 16'd1) == len_q;
        next_after_gap = last_word ? S_DONE : (fill_mode ? S_WR_REQ : S_RD_REQ);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_d        = cmd_src;
                    dst_d        = cmd_dst;
                    len_d        = cmd_len;
                    idx_d        = '0;
                    error_d      = 1'b0;
                    words_done_d = '0;
`ifdef SRAM_COPY_FILL_EN
                    fill_d       = cmd_fill;
                    pattern_d    = cmd_pattern;
`endif
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (start_fill) begin
                        state_d = S_WR_REQ;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                tmo_d   = '0;
                state_d = S_RD_ACK;
            end
            S_RD_ACK: begin
                if (!ready_sync) begin
                    tmo_d   = '0;
                    state_d = S_RD_DATA;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RD_DATA: begin
                if (ready_sync) begin
                    data_d  = DataFromSRAM;
                    state_d = S_WR_REQ;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WR_REQ: begin
                words_done_d = words_done_q + 16'd1;
                gap_d        = '0;
                // A zero-length gap skips the pacing state and advances directly.
                if (WR_GAP == 0) begin
                    idx_d   = idx_q + 16'd1;
                    state_d = next_after_gap;
                end else begin
                    state_d = S_WR_GAP;
                end
            end
            S_WR_GAP: begin
                if (gap_q == GAP_LAST) begin
                    idx_d   = idx_q + 16'd1;
                    state_d = next_after_gap;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Port outputs decoded from the current state; idle values are all zero.
    always_comb begin
        cmd_ready     = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        QueueReadReq  = (state_q == S_RD_REQ);
        QueueWriteReq = (state_q == S_WR_REQ);
        AddressToSRAM = '0;
        DataToSRAM    = '0;
        if (state_q == S_RD_REQ) begin
            AddressToSRAM = addr_at(src_q, idx_q);
        end else if (state_q == S_WR_REQ) begin
            AddressToSRAM = addr_at(dst_q, idx_q);
            DataToSRAM    = wr_data;
        end
    end

    assign error      = error_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_sram_copy_client.sv
// Self-checking bench for sram_copy_client: a responder drives the
// DataReady handshake, a command-level model predicts every request pulse.
`timescale 1ns/1ps
module tb_sram_copy_client;

    logic        BOARD_CLK = 1'b0;
    logic        RESET_N   = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [19:0] cmd_src = '0;
    logic [19:0] cmd_dst = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_fill = 1'b0;
    logic [15:0] cmd_pattern = '0;
    logic [19:0] AddressToSRAM;
    logic [15:0] DataToSRAM;
    logic        QueueReadReq;
    logic        QueueWriteReq;
    logic        DataReady = 1'b1;
    logic [15:0] DataFromSRAM = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;

    sram_copy_client #(.ACK_TIMEOUT(64), .WR_GAP(2)) dut (
        .BOARD_CLK     (BOARD_CLK),
        .RESET_N       (RESET_N),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_src       (cmd_src),
        .cmd_dst       (cmd_dst),
        .cmd_len       (cmd_len),
        .cmd_fill      (cmd_fill),
        .cmd_pattern   (cmd_pattern),
        .AddressToSRAM (AddressToSRAM),
        .DataToSRAM    (DataToSRAM),
        .QueueReadReq  (QueueReadReq),
        .QueueWriteReq (QueueWriteReq),
        .DataReady     (DataReady),
        .DataFromSRAM  (DataFromSRAM),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_done    (words_done)
    );

    always #5 BOARD_CLK = ~BOARD_CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge BOARD_CLK) cyc <= cyc + 1;

    // Model expectations and observed logs
    logic [19:0] exp_rd[$];
    logic [35:0] exp_wr[$];
    logic [19:0] rd_log[$];
    int          rd_cyc[$];
    logic [35:0] wr_log[$];
    int          wr_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic        err_at_done = 1'b0;

    // Responder controls
    logic        rsp_stuck = 1'b0;
    int          rsp_low_override = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rd_word(input logic [19:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    task automatic expect_copy(input logic [19:0] src, input logic [19:0] dst, input int len);
        for (int k = 0; k < len; k++) begin
            logic [19:0] s;
            logic [19:0] d;
            s = src + 20'(k);
            d = dst + 20'(k);
            exp_rd.push_back(s);
            exp_wr.push_back({d, rd_word(s)});
        end
    endtask

    task automatic expect_fill(input logic [19:0] dst, input int len, input logic [15:0] pat);
        for (int k = 0; k < len; k++) begin
            logic [19:0] d;
            d = dst + 20'(k);
            exp_wr.push_back({d, pat});
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        rd_cyc.delete();
        wr_log.delete();
        wr_cyc.delete();
    endtask

    // SRAM port responder: after a read pulse, drop DataReady, then raise it with the word.
    initial begin
        int          phase;
        int          cnt;
        logic [19:0] addr;
        phase = 0;
        cnt   = 0;
        addr  = '0;
        forever begin
            @(negedge BOARD_CLK);
            if (!RESET_N) begin
                phase        = 0;
                DataReady    = 1'b1;
                DataFromSRAM = 16'h0000;
            end else begin
                case (phase)
                    0: if (QueueReadReq && !rsp_stuck) begin
                        addr  = AddressToSRAM;
                        cnt   = 1 + int'(addr % 3);
                        phase = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt <= 0) begin
                            DataReady    = 1'b0;
                            DataFromSRAM = 16'hDEAD;
                            cnt   = (rsp_low_override != 0) ? rsp_low_override : 1 + int'(addr % 4);
                            phase = 2;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt <= 0) begin
                            DataFromSRAM = rd_word(addr);
                            DataReady    = 1'b1;
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle compare against the model queues
    always @(negedge BOARD_CLK) begin
        if (!RESET_N) begin
            chk("req_in_reset", {62'd0, QueueReadReq, QueueWriteReq}, 64'd0);
        end else begin
            chk("rd_wr_exclusive", {63'd0, QueueReadReq & QueueWriteReq}, 64'd0);
            chk("ready_vs_busy", {63'd0, cmd_ready}, {63'd0, ~busy});
            if (QueueReadReq) begin
                rd_log.push_back(AddressToSRAM);
                rd_cyc.push_back(cyc);
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got addr %0h, expected no read", AddressToSRAM);
                end else begin
                    chk("rd_addr", {44'd0, AddressToSRAM}, {44'd0, exp_rd.pop_front()});
                end
            end
            if (QueueWriteReq) begin
                wr_log.push_back({AddressToSRAM, DataToSRAM});
                wr_cyc.push_back(cyc);
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h/%0h, expected no write", AddressToSRAM, DataToSRAM);
                end else begin
                    chk("wr_addr_data", {28'd0, AddressToSRAM, DataToSRAM}, {28'd0, exp_wr.pop_front()});
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                err_at_done = error;
            end
        end
    end

    task automatic issue(input logic [19:0] src, input logic [19:0] dst, input logic [15:0] len,
                         input logic fill, input logic [15:0] pat, output int t);
        @(posedge BOARD_CLK);
        #1;
        cmd_valid   = 1'b1;
        cmd_src     = src;
        cmd_dst     = dst;
        cmd_len     = len;
        cmd_fill    = fill;
        cmd_pattern = pat;
        t = cyc;
        @(posedge BOARD_CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_fill  = 1'b0;
    endtask

    task automatic wait_done(input int start, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge BOARD_CLK);
            #1;
            if (done_cnt != start) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", maxc);
        end
    endtask

    task automatic finish_cmd(input string name, input int d0, input logic [15:0] exp_words, input logic exp_err);
        chk({name, "_words_done"}, {48'd0, words_done}, {48'd0, exp_words});
        chk({name, "_err_at_done"}, {63'd0, err_at_done}, {63'd0, exp_err});
        repeat (3) @(negedge BOARD_CLK);
        #1;
        chk({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
        chk({name, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    endtask

    initial begin
        int t;
        int d0;

        // Reset values
        #2 RESET_N = 1'b0;
        repeat (3) @(negedge BOARD_CLK);
        #1;
        chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_outputs", {AddressToSRAM, DataToSRAM, QueueReadReq, QueueWriteReq, busy, done, error, words_done},
            64'd0);
        @(posedge BOARD_CLK);
        #2 RESET_N = 1'b1;
        repeat (4) @(negedge BOARD_CLK);

        // Copy 0x00100 -> 0x00200, 4 words; cmd_valid while busy must be ignored
        clear_logs();
        expect_copy(20'h00100, 20'h00200, 4);
        d0 = done_cnt;
        issue(20'h00100, 20'h00200, 16'd4, 1'b0, 16'h0000, t);
        repeat (2) @(posedge BOARD_CLK);
        #1;
        cmd_valid = 1'b1;
        cmd_src   = 20'h55555;
        cmd_len   = 16'd9;
        repeat (5) @(posedge BOARD_CLK);
        #1;
        cmd_valid = 1'b0;
        wait_done(d0, 400);
        finish_cmd("copy4", d0, 16'd4, 1'b0);
        chk("copy4_first_rd_cycle", 64'(rd_cyc[0]), 64'(t + 1));
        chk("copy4_rd_count", 64'(rd_log.size()), 64'd4);
        chk("copy4_last_rd", {44'd0, rd_log[3]}, 64'h00103);
        chk("copy4_first_wr", {28'd0, wr_log[0]}, {28'd0, 20'h00200, 16'hA4C3});

        // len = 0: done one cycle after accept, no requests
        clear_logs();
        d0 = done_cnt;
        issue(20'h00123, 20'h00456, 16'd0, 1'b0, 16'h0000, t);
        wait_done(d0, 20);
        chk("len0_done_cycle", 64'(done_cyc), 64'(t + 1));
        finish_cmd("len0", d0, 16'd0, 1'b0);
        chk("len0_no_reqs", 64'(rd_log.size() + wr_log.size()), 64'd0);

        // Timeout: DataReady never drops
        clear_logs();
        rsp_stuck = 1'b1;
        exp_rd.push_back(20'h00400);
        d0 = done_cnt;
        issue(20'h00400, 20'h00480, 16'd2, 1'b0, 16'h0000, t);
        wait_done(d0, 200);
        chk("tmo_done_cycle", 64'(done_cyc), 64'(t + 66));
        finish_cmd("tmo", d0, 16'd0, 1'b1);
        chk("tmo_ready_after", {63'd0, cmd_ready}, 64'd1);
        chk("tmo_error_sticky", {63'd0, error}, 64'd1);
        rsp_stuck = 1'b0;

        // Address wrap; accept clears the sticky error
        clear_logs();
        expect_copy(20'hFFFFE, 20'h00300, 3);
        d0 = done_cnt;
        issue(20'hFFFFE, 20'h00300, 16'd3, 1'b0, 16'h0000, t);
        wait_done(d0, 300);
        finish_cmd("wrap", d0, 16'd3, 1'b0);
        chk("wrap_rd0", {44'd0, rd_log[0]}, 64'hFFFFE);
        chk("wrap_rd1", {44'd0, rd_log[1]}, 64'hFFFFF);
        chk("wrap_rd2", {44'd0, rd_log[2]}, 64'h00000);
        chk("wrap_wr2", {28'd0, wr_log[2]}, {28'd0, 20'h00302, 16'hA5C3});

`ifdef SRAM_COPY_FILL_EN
        // Fill: three writes of the pattern, one every three cycles, no reads
        clear_logs();
        expect_fill(20'h00010, 3, 16'hBEEF);
        d0 = done_cnt;
        issue(20'h00900, 20'h00010, 16'd3, 1'b1, 16'hBEEF, t);
        wait_done(d0, 100);
        finish_cmd("fill", d0, 16'd3, 1'b0);
        chk("fill_no_reads", 64'(rd_log.size()), 64'd0);
        chk("fill_first_wr_cycle", 64'(wr_cyc[0]), 64'(t + 1));
        chk("fill_spacing01", 64'(wr_cyc[1] - wr_cyc[0]), 64'd3);
        chk("fill_spacing12", 64'(wr_cyc[2] - wr_cyc[1]), 64'd3);
        chk("fill_last_wr", {28'd0, wr_log[2]}, {28'd0, 20'h00012, 16'hBEEF});
`else
        // Fill request without the feature behaves as a copy
        clear_logs();
        expect_copy(20'h00900, 20'h00010, 3);
        d0 = done_cnt;
        issue(20'h00900, 20'h00010, 16'd3, 1'b1, 16'hBEEF, t);
        wait_done(d0, 300);
        finish_cmd("nofill", d0, 16'd3, 1'b0);
        chk("nofill_rd_count", 64'(rd_log.size()), 64'd3);
        chk("nofill_first_wr", {28'd0, wr_log[0]}, {28'd0, 20'h00010, 16'hACC3});
`endif

        // Reset while waiting for read data
        clear_logs();
        rsp_low_override = 40;
        exp_rd.push_back(20'h00500);
        issue(20'h00500, 20'h00600, 16'd2, 1'b0, 16'h0000, t);
        for (int k = 0; k < 20 && rd_log.size() == 0; k++) begin
            @(negedge BOARD_CLK);
            #1;
        end
        chk("rstmid_read_seen", 64'(rd_log.size()), 64'd1);
        repeat (8) @(negedge BOARD_CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("rstmid_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rstmid_outputs", {AddressToSRAM, DataToSRAM, QueueReadReq, QueueWriteReq, busy, done, error, words_done},
            64'd0);
        exp_rd.delete();
        exp_wr.delete();
        rsp_low_override = 0;
        repeat (3) @(negedge BOARD_CLK);
        @(posedge BOARD_CLK);
        #2 RESET_N = 1'b1;
        repeat (5) @(negedge BOARD_CLK);
        #1;
        chk("rstmid_idle_after", {62'd0, cmd_ready, busy}, 64'h2);

        // Clean command after the abort
        clear_logs();
        expect_copy(20'h00700, 20'h00800, 2);
        d0 = done_cnt;
        issue(20'h00700, 20'h00800, 16'd2, 1'b0, 16'h0000, t);
        wait_done(d0, 300);
        finish_cmd("post_rst", d0, 16'd2, 1'b0);
        chk("post_rst_first_rd_cycle", 64'(rd_cyc[0]), 64'(t + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 ns, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_copy_client.md
# sram_copy_client

Single-port block-copy engine on the client side of one SRAM controller port, clocked on BOARD_CLK. Accepts a copy (or fill) command, issues one-cycle read requests into the controller port, waits for the DataReady low/high handshake, then queues the captured word as a write to the destination address. Lets rasterizer and framebuffer logic move SRAM regions without owning the port protocol.

## Interface
- ACK_TIMEOUT, 64: BOARD_CLK cycles allowed per read-handshake phase before abort.
- WR_GAP, 2: idle cycles inserted after each write request; throttles controller FIFO fill.
- BOARD_CLK  in  1  fabric clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid && cmd_ready.
- cmd_src  in  20  source word address.
- cmd_dst  in  20  destination word address.
- cmd_len  in  16  word count; 0 = no-op.
- cmd_fill  in  1  fill mode (see Configuration).
- cmd_pattern  in  16  fill word.
- AddressToSRAM  out  20  request address to controller port.
- DataToSRAM  out  16  write data to controller port.
- QueueReadReq  out  1  one-cycle read request pulse.
- QueueWriteReq  out  1  one-cycle write request pulse.
- DataReady  in  1  controller port ready flag (SRAM_CLK domain).
- DataFromSRAM  in  16  controller read data, valid while DataReady high.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at command end (normal or abort).
- error  out  1  sticky timeout flag; cleared on next accept.
- words_done  out  16  words written for current/last command.

## Operation
- Reset values: cmd_ready=1, all other outputs 0, state IDLE. Reset mid-command aborts immediately; no request pulse may be emitted while RESET_N low.
- DataReady passes through a 2-flop synchronizer; all handshake decisions use the synchronized value.
- States: IDLE, RD_REQ, RD_ACK, RD_DATA, WR_REQ, WR_GAP, DONE.
- IDLE: on accept latch src, dst, len, fill, pattern; clear error, words_done, index i. len=0 -> DONE. Fill -> WR_REQ. Else -> RD_REQ.
- RD_REQ: QueueReadReq=1, AddressToSRAM=src+i for one cycle -> RD_ACK.
- RD_ACK: wait synchronized DataReady=0 -> RD_DATA.
- RD_DATA: wait synchronized DataReady=1; capture DataFromSRAM -> WR_REQ.
- Timeout: each of RD_ACK/RD_DATA reloads a counter on entry; ACK_TIMEOUT cycles without the awaited level -> error=1, DONE.
- WR_REQ: QueueWriteReq=1, AddressToSRAM=dst+i, DataToSRAM=captured word (or pattern) for one cycle; words_done++ -> WR_GAP.
- WR_GAP: WR_GAP cycles; then i++; i==len -> DONE, else RD_REQ (copy) or WR_REQ (fill).
- DONE: done=1, busy=0 next cycle -> IDLE.
- Address arithmetic modulo 2^20: 0xFFFFF+1 wraps to 0x00000. Index i is 16 bits; len 0xFFFF is max.
- QueueReadReq and QueueWriteReq are never high in the same cycle. cmd_valid while busy is ignored.

## Timing
- Accept at cycle T; QueueReadReq at T+1 (copy) or QueueWriteReq at T+1 (fill).
- Fill throughput: one write per 1+WR_GAP cycles.
- Copy per word: 1 (RD_REQ) + ack wait + data wait + 1 (WR_REQ) + WR_GAP; synchronizer adds 2 cycles to each observed edge.
- Read capture uses DataFromSRAM in the cycle synchronized DataReady is first seen high; controller holds data stable while DataReady high.
- done pulses exactly once per accepted command, including len=0 (at T+1) and timeout.

## Configuration
- SRAM_COPY_FILL_EN defined: cmd_fill=1 selects fill mode, writing cmd_pattern to dst..dst+len-1 with no reads.
- Undefined: cmd_fill and cmd_pattern ignored, fill path and pattern register removed; every command is a copy.

## Structure
- Package sram_client_pkg: state enum, SRAM_ADDR_W=20, SRAM_DATA_W=16, shared with other controller clients.
- One sub-module: sram_sync2 (2-flop level synchronizer, reset to 0), instantiated for DataReady.

## Test plan
- Copy src=0x00100 dst=0x00200 len=4, responder model drops/raises DataReady per read -> 4 read pulses at 0x00100..0x00103, 4 write pulses at 0x00200..0x00203 with returned data, words_done=4, one done.
- Wrap: src=0xFFFFE len=3 -> read addresses 0xFFFFE, 0xFFFFF, 0x00000.
- len=0 -> no request pulses, done at T+1, error=0.
- Responder never drops DataReady, ACK_TIMEOUT=64 -> error=1 after 64 cycles in RD_ACK, done pulse, words_done=0, cmd_ready=1 next.
- With SRAM_COPY_FILL_EN, fill dst=0x00010 len=3 pattern=0xBEEF -> three write pulses spaced 1+WR_GAP cycles, data 0xBEEF, no read pulses.
- RESET_N low during RD_DATA -> all outputs 0 asynchronously, IDLE after release; new command runs cleanly.
